mux4way_arbiter: RTL

- Round-robin arbiter that shares one Mux4Way datapath among four requesters (inputs a, b, c, d).
- Grants one requester at a time and drives the mux select from the registered grant.
- Holds a grant while the owner keeps requesting. Preempts the owner after HOLD_MAX cycles when another requester is waiting.
- Sits between requester logic and the Mux4Way select input.

---
 rtl/mux4way_arbiter_pkg.sv | 22 ++
 rtl/mux4way_arbiter_pick.sv | 28 ++
 rtl/mux4way_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/mux4way_arbiter_pkg.sv
// Shared types and constants for the Mux4Way round-robin arbiter.
// Holds the FSM state encoding, the mux input indices and a decode helper.
package mux4way_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [1:0] IDX_A = 2'd0;
   localparam logic [1:0] IDX_B = 2'd1;
   localparam logic [1:0] IDX_C = 2'd2;
   localparam logic [1:0] IDX_D = 2'd3;

   function automatic logic [3:0] idx2onehot(input logic [1:0] idx);
      logic [3:0] oh;
      oh = 4'b0000;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux4way_arbiter_pick.sv
// rr_pick4: combinational round-robin picker over four request bits.
// Ports: req[3:0], ptr[1:0] in; any (some bit set), idx[1:0] (first set bit at/after ptr) out.
module rr_pick4
   import mux4way_arbiter_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic       any,
   output logic [1:0] idx
);

   logic [1:0] pos;

   // Walk from the farthest offset back to ptr so the nearest set bit wins.
   always_comb begin
      any = 1'b0;
      idx = IDX_A;
      pos = ptr;
      for (int i = 3; i >= 0; i--) begin
         pos = ptr + 2'(i);
         if (req[pos]) begin
            any = 1'b1;
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/mux4way_arbiter.sv
// Round-robin arbiter sharing one Mux4Way among four requesters with hold limit.
// Ports: clk, rst_n (sync, active-low), req[3:0] in; gnt[3:0], sel[1:0], busy out.
module mux4way_arbiter
   import mux4way_arbiter_pkg::*;
#(
   parameter int HOLD_MAX = 4,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

   state_t           state, state_n;
   logic [3:0]       gnt_n;
   logic [1:0]       sel_n;
   logic [1:0]       ptr, ptr_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   logic             pick_any;
   logic [1:0]       pick_idx;
   logic             owner_req;
   logic             others_req;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   // In GRANT, sel always holds the owner index.
   assign owner_req  = req[sel];
   assign others_req = |(req & ~gnt);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         gnt   <= 4'b0000;
         sel   <= IDX_A;
         ptr   <= IDX_A;
         cnt   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         sel   <= sel_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sel_n   = sel;
      ptr_n   = ptr;
      cnt_n   = cnt;
      unique case (state)
         ST_IDLE: begin
            gnt_n = 4'b0000;
            if (pick_any) begin
               gnt_n   = idx2onehot(pick_idx);
               sel_n   = pick_idx;
               cnt_n   = '0;
               state_n = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // Release and preempt both leave one idle cycle before the next owner.
            if (!owner_req || (cnt == CNT_MAX && others_req)) begin
               gnt_n   = 4'b0000;
               ptr_n   = sel + 2'd1;
               state_n = ST_IDLE;
            end else if (cnt != CNT_MAX) begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            gnt_n   = 4'b0000;
         end
      endcase
   end

   assign busy = |gnt;

endmodule
